// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared constants for the FIFO write-side arbiter
// Holds the FSM state encoding, the parameter defaults and the credit-counter width.
package fifo_arb_pkg;
    localparam int N_REQ_DEF     = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int PTR_WIDTH_DEF = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int CREDIT_W      = PTR_WIDTH_DEF + 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
// Ports: i_req   request vector
//        i_ptr   last granted index; the search starts at i_ptr+1, so i_ptr itself ranks last
//        o_pick  one-hot winner (0 when nothing requests)
//        o_idx   binary index of the winner
//        o_valid at least one request present
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % N]) begin
                o_valid = 1'b1;
                o_idx   = IW'((int'(i_ptr) + i) % N);
                o_pick[(int'(i_ptr) + i) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port between N_REQ producers
// Ports: clk_i/rst_i          clock, async active-high reset
//        req_valid_i/data_i   producer handshake inputs, req_ready_o back to producers
//        grant_o              one-hot current owner, 0 when idle
//        fifo_wdata_o/wr_en_o registered FIFO write port
//        fifo_rd_en_i/empty_i observed FIFO reads, used to return credits
//        fifo_wr_error_i      FIFO overflow indication, latched into err_o
//        credit_o             free FIFO entries as seen by the arbiter
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic [WIDTH-1:0]       fifo_wdata_o,
    output logic                   fifo_wr_en_o,
    input  logic                   fifo_rd_en_i,
    input  logic                   fifo_empty_i,
    input  logic                   fifo_wr_error_i,
    output logic [PTR_WIDTH:0]     credit_o,
    output logic                   err_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int CW = PTR_WIDTH + 1;

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IW-1:0]    r_ptr;
    logic [BW-1:0]    r_beat_cnt;
    logic [CW-1:0]    r_credit;
    logic             r_err;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_wdata;

    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_pick;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic [WIDTH-1:0] w_data;
    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic             w_rd;

    // In GRANT, r_ptr is the holder index, so it both selects the data lane and
    // makes the holder lowest priority at handover.
    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_ready   = r_grant & {N_REQ{r_credit != '0}};
    assign w_accept  = |(req_valid_i & w_ready);
    assign w_data    = req_data_i[r_ptr*WIDTH +: WIDTH];
    assign w_last    = w_accept && (r_beat_cnt == BW'(MAX_BURST - 1));
    assign w_release = (r_state == ST_GRANT) && (!(|(req_valid_i & r_grant)) || w_last);
    assign w_rd      = fifo_rd_en_i & ~fifo_empty_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_ptr      <= IW'(N_REQ - 1);
            r_beat_cnt <= '0;
            r_credit   <= CW'(DEPTH);
            r_err      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_wr_en  <= w_accept;
            r_wdata  <= w_accept ? w_data : '0;
            r_credit <= r_credit + CW'(w_rd) - CW'(w_accept);
            r_err    <= r_err | fifo_wr_error_i;
            // IDLE and a releasing GRANT share the same re-pick; an empty pick lands in IDLE.
            if (r_state == ST_IDLE || w_release) begin
                r_state    <= w_pick_valid ? ST_GRANT : ST_IDLE;
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
                if (w_pick_valid) r_ptr <= w_pick_idx;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign grant_o      = r_grant;
    assign fifo_wdata_o = r_wdata;
    assign fifo_wr_en_o = r_wr_en;
    assign credit_o     = r_credit;
    assign err_o        = r_err;
endmodule
